// File: rtl/imem_ctrl_pkg.sv
// Shared constants for the instruction-memory controller: word width, BRAM depth
// and FSM state encodings.
// Latency: n/a (constants only).
// Backpressure: n/a.
package imem_ctrl_pkg;

  // Instruction word width and instruction BRAM depth (in words).
  localparam int RV_DATA_WIDTH = 32;
  localparam int I_BRAM_DEPTH  = 1024;

  // Load/run FSM encodings. The fourth code is unused and decodes back to IDLE.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

endpackage

// File: rtl/imem_ctrl.sv
// Instruction-memory controller: streams a program into the BRAM write port,
// then serves core fetches from the BRAM read port.
// Latency: a load word is written in its handshake cycle; a fetch response
// appears one cycle after the request.
// Backpressure: ld_ready is high only in LOAD; fetch_ready is high only in RUN.
// Neither handshake stalls within its own state.
//
// Ports:
//   clk, rst                      clock, async active-low reset
//   load_start, load_len          load command and word count
//   ld_valid/ld_ready, ld_data    load-word stream
//   load_busy/done/err            load status
//   fetch_req/ready, fetch_pc     core fetch request (byte PC)
//   fetch_valid/misalign/instr    fetch response
//   bram_w_*, bram_r_*            BRAM write and read ports
module imem_ctrl
  import imem_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = RV_DATA_WIDTH,
  parameter int DEPTH      = I_BRAM_DEPTH,
  parameter int AW         = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_start,
  input  logic [AW:0]           load_len,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [DATA_WIDTH-1:0] ld_data,
  output logic                  load_busy,
  output logic                  load_done,
  output logic                  load_err,
  input  logic                  fetch_req,
  output logic                  fetch_ready,
  input  logic [31:0]           fetch_pc,
  output logic                  fetch_valid,
  output logic                  fetch_misalign,
  output logic [DATA_WIDTH-1:0] fetch_instr,
  output logic [AW-1:0]         bram_w_addr,
  output logic [DATA_WIDTH-1:0] bram_w_dat,
  output logic                  bram_w_enb,
  output logic [AW-1:0]         bram_r_addr,
  output logic                  bram_r_enb,
  input  logic [DATA_WIDTH-1:0] bram_r_dat
);

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [AW:0]   remain_q, remain_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          fvalid_q, fvalid_d;
  logic          fmis_q, fmis_d;

  logic st_load, st_run;
  logic len_ok, wr_fire, rd_req, aligned;

  // PC bits above the BRAM word address are ignored, so fetches wrap modulo DEPTH.
  logic unused_pc_hi;
  assign unused_pc_hi = ^fetch_pc[31:AW+2];

  assign st_load = (state_q == ST_LOAD);
  assign st_run  = (state_q == ST_RUN);
  assign len_ok  = (load_len != '0) && (load_len <= DEPTH_L);
  assign aligned = (fetch_pc[1:0] == 2'b00);
  assign wr_fire = ld_valid & st_load;
  assign rd_req  = fetch_req & st_run;

  assign ld_ready    = st_load;
  assign load_busy   = st_load;
  assign fetch_ready = st_run;
  assign load_done   = done_q;
  assign load_err    = err_q;

  // Writes are only possible in LOAD and reads only in RUN, so the two
  // enables are mutually exclusive by construction.
  assign bram_w_enb  = wr_fire;
  assign bram_w_addr = waddr_q;
  assign bram_w_dat  = ld_data;
  assign bram_r_enb  = rd_req & aligned;
  assign bram_r_addr = fetch_pc[AW+1:2];

  // Read data arrives one cycle after the enable, aligned with fvalid_q.
  assign fetch_valid    = fvalid_q;
  assign fetch_misalign = fmis_q;
  assign fetch_instr    = fvalid_q ? bram_r_dat : '0;

  always_comb begin
    state_d  = state_q;
    waddr_d  = waddr_q;
    remain_d = remain_q;
    done_d   = done_q;
    err_d    = err_q;
    fvalid_d = rd_req & aligned;
    fmis_d   = rd_req & ~aligned;

    case (state_q)
      ST_IDLE, ST_RUN: begin
        if (load_start) begin
          if (len_ok) begin
            state_d  = ST_LOAD;
            waddr_d  = '0;
            remain_d = load_len;
            done_d   = 1'b0;
            err_d    = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        // load_start is ignored while a load is in progress.
        if (wr_fire) begin
          waddr_d  = waddr_q + AW'(1);
          remain_d = remain_q - (AW+1)'(1);
          if (remain_q == (AW+1)'(1)) begin
            state_d = ST_RUN;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      waddr_q  <= '0;
      remain_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      fvalid_q <= 1'b0;
      fmis_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      waddr_q  <= waddr_d;
      remain_q <= remain_d;
      done_q   <= done_d;
      err_q    <= err_d;
      fvalid_q <= fvalid_d;
      fmis_q   <= fmis_d;
    end
  end

endmodule
